// File: rtl/mat_sys_pkg.sv
// Shared constants and types for the matrix-side memory subsystem.
package mat_sys_pkg;

    localparam int unsigned DATA_W = 256;
    localparam int unsigned ADDR_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RELEASE
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request strictly after ptr_i,
// wrapping around, with ptr_i itself checked last.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] sel_o,
    output logic [PTR_W-1:0]   idx_o
);

    always_comb begin
        sel_o = '0;
        idx_o = '0;
        // Scan farthest-first so the nearest requester after ptr_i overwrites the rest.
        for (int unsigned off = NUM_REQ; off >= 1; off--) begin
            logic [PTR_W-1:0] k;
            k = PTR_W'((32'(ptr_i) + off) % NUM_REQ);
            if (req_i[k]) begin
                sel_o    = '0;
                sel_o[k] = 1'b1;
                idx_o    = k;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the single Mem port between matrix-side requesters,
// one outstanding transaction at a time, with a per-transaction timeout.
module mem_port_arbiter
    import mat_sys_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      RESET,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        rw_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic [NUM_REQ-1:0]        done_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      timeout_o,
    output logic                      memEN,
    output logic                      memRW,
    output logic [ADDR_W-1:0]         memAddr,
    output logic [DATA_W-1:0]         memWrite,
    input  logic [DATA_W-1:0]         fromMemBus,
    input  logic                      memFleg
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    arb_state_t         state_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   gidx_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [NUM_REQ-1:0] pick_sel;
    logic [PTR_W-1:0]   pick_idx;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .sel_o (pick_sel),
        .idx_o (pick_idx)
    );

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            ptr_q     <= PTR_W'(NUM_REQ - 1);
            gidx_q    <= '0;
            cnt_q     <= '0;
            grant_o   <= '0;
            done_o    <= '0;
            rdata_o   <= '0;
            timeout_o <= 1'b0;
            memEN     <= 1'b0;
            memRW     <= 1'b0;
            memAddr   <= '0;
            memWrite  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req_i) begin
                        grant_o  <= pick_sel;
                        gidx_q   <= pick_idx;
                        memRW    <= rw_i[pick_idx];
                        memAddr  <= addr_i[pick_idx*ADDR_W +: ADDR_W];
                        memWrite <= wdata_i[pick_idx*DATA_W +: DATA_W];
                        memEN    <= 1'b1;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    memEN   <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // A completion on the expiry cycle beats the timeout.
                    if (memFleg) begin
                        if (!memRW) begin
                            rdata_o <= fromMemBus;
                        end
                        done_o  <= grant_o;
                        state_q <= RELEASE;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        timeout_o <= 1'b1;
                        done_o    <= grant_o;
                        state_q   <= RELEASE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    grant_o <= '0;
                    done_o  <= '0;
                    ptr_q   <= gidx_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level reference model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_mem_port_arbiter;

    localparam int NR = 4;
    localparam int AW = 8;
    localparam int DW = 256;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           RESET;
    logic [NR-1:0]  req_i, rw_i;
    logic [NR*AW-1:0] addr_i;
    logic [NR*DW-1:0] wdata_i;
    logic [NR-1:0]  grant_o, done_o;
    logic [DW-1:0]  rdata_o, memWrite, fromMemBus;
    logic           timeout_o, memEN, memRW, memFleg;
    logic [AW-1:0]  memAddr;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(
        .NUM_REQ (NR),
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .RESET      (RESET),
        .req_i      (req_i),
        .rw_i       (rw_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .grant_o    (grant_o),
        .done_o     (done_o),
        .rdata_o    (rdata_o),
        .timeout_o  (timeout_o),
        .memEN      (memEN),
        .memRW      (memRW),
        .memAddr    (memAddr),
        .memWrite   (memWrite),
        .fromMemBus (fromMemBus),
        .memFleg    (memFleg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: owner of the port, cycles since grant, and the visible outputs.
    int            m_ptr = NR - 1;
    int            m_owner = -1;
    int            m_age = 0;
    bit            m_fin = 1'b0;
    logic [NR-1:0] m_grant = '0, m_done = '0;
    logic [DW-1:0] m_rdata = '0, m_wdata = '0;
    logic [AW-1:0] m_addr = '0;
    logic          m_to = 1'b0, m_en = 1'b0, m_rw = 1'b0;

    task automatic model_step();
        if (RESET) begin
            m_ptr = NR - 1; m_owner = -1; m_age = 0; m_fin = 1'b0;
            m_grant = '0; m_done = '0; m_rdata = '0; m_wdata = '0;
            m_addr = '0; m_to = 1'b0; m_en = 1'b0; m_rw = 1'b0;
        end else if (m_owner < 0) begin
            if (req_i != '0) begin
                for (int s = NR; s >= 1; s--) begin
                    if (req_i[(m_ptr + s) % NR]) m_owner = (m_ptr + s) % NR;
                end
                m_grant = '0;
                m_grant[m_owner] = 1'b1;
                m_en    = 1'b1;
                m_rw    = rw_i[m_owner];
                m_addr  = addr_i[m_owner*AW +: AW];
                m_wdata = wdata_i[m_owner*DW +: DW];
                m_age   = 0;
            end
        end else if (m_fin) begin
            m_grant = '0; m_done = '0; m_ptr = m_owner; m_owner = -1; m_fin = 1'b0;
        end else begin
            m_en = 1'b0;
            if (m_age >= 1 && memFleg) begin
                if (!m_rw) m_rdata = fromMemBus;
                m_done = m_grant; m_fin = 1'b1;
            end else if (m_age == TO) begin
                m_to = 1'b1; m_done = m_grant; m_fin = 1'b1;
            end
            m_age++;
        end
    endtask

    initial forever begin
        @(posedge clk or posedge RESET);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        chk("cyc_grant", DW'(grant_o), DW'(m_grant));
        chk("cyc_done", DW'(done_o), DW'(m_done));
        chk("cyc_rdata", rdata_o, m_rdata);
        chk("cyc_timeout", DW'(timeout_o), DW'(m_to));
        chk("cyc_memEN", DW'(memEN), DW'(m_en));
        chk("cyc_memRW", DW'(memRW), DW'(m_rw));
        chk("cyc_memAddr", DW'(memAddr), DW'(m_addr));
        chk("cyc_memWrite", memWrite, m_wdata);
    end

    task automatic wait_en(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (memEN) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk); RESET = 1'b1;
        @(negedge clk); RESET = 1'b0;
    endtask

    logic [DW-1:0] rd_a5, wr_w, junk, d2, d3;
    logic [NR-1:0] got [5];
    logic [NR-1:0] exp_rr [5];
    bit ok;
    int n;

    initial begin
        rd_a5 = {32{8'hA5}};
        wr_w  = {8{32'hDEADBEEF}};
        junk  = {16{16'h1234}};
        d2    = {4{64'h0123456789ABCDEF}};
        d3    = {8{32'h5A5A0F0F}};
        exp_rr[0] = 4'b0001; exp_rr[1] = 4'b0010; exp_rr[2] = 4'b0100;
        exp_rr[3] = 4'b1000; exp_rr[4] = 4'b0001;

        RESET = 1'b1; req_i = '0; rw_i = '0; addr_i = '0; wdata_i = '0;
        fromMemBus = '0; memFleg = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_grant", DW'(grant_o), '0);
        chk("rst_memEN", DW'(memEN), '0);
        chk("rst_timeout", DW'(timeout_o), '0);
        chk("rst_rdata", rdata_o, '0);
        RESET = 1'b0;
        @(negedge clk);

        // memFleg while idle must not touch rdata_o
        fromMemBus = junk; memFleg = 1'b1;
        @(negedge clk); memFleg = 1'b0;
        @(negedge clk);
        chk("idle_fleg_ignored", rdata_o, '0);

        // Round robin with all four requesting
        req_i = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_en(ok);
            chk("rr_en_seen", DW'(ok), DW'(1));
            got[i] = grant_o;
            @(negedge clk); fromMemBus = DW'(i + 1); memFleg = 1'b1;
            @(negedge clk); memFleg = 1'b0;
        end
        req_i = '0;
        for (int i = 0; i < 5; i++) chk("rr_order", DW'(got[i]), DW'(exp_rr[i]));
        repeat (2) @(negedge clk);
        pulse_reset();
        @(negedge clk);

        // Single read from requester 0
        addr_i[7:0] = 8'h10; rw_i[0] = 1'b0; req_i = 4'b0001;
        wait_en(ok);
        chk("t1_en_seen", DW'(ok), DW'(1));
        chk("t1_addr", DW'(memAddr), DW'(8'h10));
        chk("t1_rw", DW'(memRW), '0);
        chk("t1_grant", DW'(grant_o), DW'(4'b0001));
        req_i = '0;
        @(negedge clk);
        chk("t1_en_pulse", DW'(memEN), '0);
        fromMemBus = rd_a5; memFleg = 1'b1;
        @(negedge clk); memFleg = 1'b0; fromMemBus = '0;
        chk("t1_done", DW'(done_o), DW'(4'b0001));
        chk("t1_rdata", rdata_o, rd_a5);
        @(negedge clk);
        chk("t1_grant_drop", DW'(grant_o), '0);
        chk("t1_done_drop", DW'(done_o), '0);

        // Write from requester 2; inputs changed after the sample are ignored
        rw_i[2] = 1'b1; addr_i[23:16] = 8'h3C; wdata_i[2*DW +: DW] = wr_w; req_i = 4'b0100;
        wait_en(ok);
        chk("t3_en_seen", DW'(ok), DW'(1));
        addr_i[23:16] = 8'hFF; req_i = '0;
        chk("t3_rw", DW'(memRW), DW'(1));
        chk("t3_addr", DW'(memAddr), DW'(8'h3C));
        chk("t3_wdata", memWrite, wr_w);
        chk("t3_grant", DW'(grant_o), DW'(4'b0100));
        @(negedge clk); fromMemBus = junk; memFleg = 1'b1;
        @(negedge clk); memFleg = 1'b0;
        chk("t3_done", DW'(done_o), DW'(4'b0100));
        chk("t3_rdata_kept", rdata_o, rd_a5);
        @(negedge clk);
        chk("t3_addr_held", DW'(memAddr), DW'(8'h3C));
        rw_i = '0;

        // Timeout: memFleg never comes
        req_i = 4'b0010;
        wait_en(ok);
        chk("t4_en_seen", DW'(ok), DW'(1));
        req_i = '0;
        n = 0;
        while (!done_o && n < 50) begin
            @(negedge clk); n++;
        end
        chk("t4_latency", DW'(n), DW'(TO + 1));
        chk("t4_timeout", DW'(timeout_o), DW'(1));
        @(negedge clk);
        req_i = 4'b0001;
        wait_en(ok);
        chk("t4_next_en", DW'(ok), DW'(1));
        req_i = '0;
        @(negedge clk); fromMemBus = d2; memFleg = 1'b1;
        @(negedge clk); memFleg = 1'b0;
        chk("t4_next_done", DW'(done_o), DW'(4'b0001));
        chk("t4_sticky", DW'(timeout_o), DW'(1));
        chk("t4_next_rdata", rdata_o, d2);
        pulse_reset();
        chk("t4_cleared", DW'(timeout_o), '0);

        // memFleg on the expiry cycle wins over the timeout
        req_i = 4'b0001;
        wait_en(ok);
        req_i = '0;
        repeat (TO) @(negedge clk);
        chk("t4b_no_early_done", DW'(done_o), '0);
        fromMemBus = d3; memFleg = 1'b1;
        @(negedge clk); memFleg = 1'b0;
        chk("t4b_done", DW'(done_o), DW'(4'b0001));
        chk("t4b_no_timeout", DW'(timeout_o), '0);
        chk("t4b_rdata", rdata_o, d3);
        repeat (2) @(negedge clk);

        // Asynchronous reset while waiting
        req_i = 4'b0001;
        wait_en(ok);
        req_i = '0;
        @(negedge clk);
        #2 RESET = 1'b1;
        #1;
        chk("t5_grant", DW'(grant_o), '0);
        chk("t5_done", DW'(done_o), '0);
        chk("t5_memEN", DW'(memEN), '0);
        chk("t5_memAddr", DW'(memAddr), '0);
        chk("t5_rdata", rdata_o, '0);
        chk("t5_memWrite", memWrite, '0);
        @(negedge clk); RESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_no_done", DW'(done_o), '0);
        end
        req_i = 4'b1010;
        wait_en(ok);
        chk("t5_en_seen", DW'(ok), DW'(1));
        chk("t5_first_grant", DW'(grant_o), DW'(4'b0010));
        req_i = '0;
        @(negedge clk); fromMemBus = junk; memFleg = 1'b1;
        @(negedge clk); memFleg = 1'b0;
        chk("t5_done_after", DW'(done_o), DW'(4'b0010));
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
